regfile_test_port: RTL and testbench

- Responder side of the register-file test-access protocol; sits inside the test skeleton between the processor and the register file.
- Normal mode: passes processor regfile control straight through.
- On a test request: stalls the processor, drains in-flight writebacks, then grants a testbench-facing port.
- The granted port supports single read/write transactions (valid/ready, registered read response) and an auto-incrementing full-regfile dump stream.

---
 rtl/regfile_test_pkg.sv | 18 +
 rtl/test_port_resp_reg.sv | 45 ++++
 rtl/regfile_test_port.sv | 165 ++++++++++++++++
 tb/tb_regfile_test_port.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_test_pkg.sv
// Shared constants and state encoding for the register-file test-access responder.
package regfile_test_pkg;

  localparam int RF_NUM_REGS     = 32;
  localparam int RF_ADDR_W       = 5;
  localparam int RF_DATA_W       = 32;
  localparam int RF_DRAIN_CYCLES = 4;

  localparam logic [RF_ADDR_W-1:0] R0_ADDR = '0;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_TEST   = 2'd2,
    ST_DUMP   = 2'd3
  } state_e;

endpackage

// File: rtl/test_port_resp_reg.sv
// Registered read-response stage shared by single reads and the dump stream.
module test_port_resp_reg #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_i,
  input  logic              last_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Address/data hold their last value between responses; only valid pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= issue_i;
      done_q  <= issue_i & last_i;
      if (issue_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/regfile_test_port.sv
// Test-access responder: passes processor regfile traffic through, or stalls,
// drains and hands the regfile to a test port with single transactions and a full dump.
module regfile_test_port
  import regfile_test_pkg::*;
#(
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int DATA_W       = RF_DATA_W,
  parameter int DRAIN_CYCLES = RF_DRAIN_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              test_req,
  output logic              test_grant,
  input  logic              t_valid,
  output logic              t_ready,
  input  logic              t_we,
  input  logic [ADDR_W-1:0] t_addr,
  input  logic [DATA_W-1:0] t_wdata,
  input  logic              dump_start,
  output logic              dump_done,
  output logic              r_valid,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic [ADDR_W-1:0] p_raddrA,
  input  logic [ADDR_W-1:0] p_raddrB,
  output logic              proc_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddrA,
  output logic [ADDR_W-1:0] rf_raddrB,
  input  logic [DATA_W-1:0] rf_rdataA
);

  localparam int                DRAIN_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [ADDR_W-1:0]  dump_q, dump_d;
  logic               stall_q, grant_q, ready_q;

  logic               accept;
  logic               issue;
  logic               last_beat;
  logic [ADDR_W-1:0]  issue_addr;
  logic [DATA_W-1:0]  issue_data;

  assign accept = (state_q == ST_TEST) && t_valid;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    dump_d  = dump_q;
    case (state_q)
      ST_NORMAL: begin
        if (test_req) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (!test_req) begin
          state_d = ST_NORMAL;
        end else if (drain_q == '0) begin
          state_d = ST_TEST;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      ST_TEST: begin
        // A transaction in flight keeps us here; a release or dump is handled on an idle cycle.
        if (!t_valid) begin
          if (!test_req) begin
            state_d = ST_NORMAL;
          end else if (dump_start) begin
            state_d = ST_DUMP;
            dump_d  = '0;
          end
        end
      end
      ST_DUMP: begin
        dump_d = dump_q + ADDR_W'(1);
        if (dump_q == LAST_ADDR) begin
          state_d = ST_TEST;
          dump_d  = '0;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    rf_we      = p_we;
    rf_waddr   = p_waddr;
    rf_wdata   = p_wdata;
    rf_raddrA  = p_raddrA;
    issue      = 1'b0;
    last_beat  = 1'b0;
    issue_addr = t_addr;
    case (state_q)
      ST_TEST: begin
        rf_we     = accept && t_we && (t_addr != ADDR_W'(R0_ADDR));
        rf_waddr  = t_addr;
        rf_wdata  = t_wdata;
        rf_raddrA = t_addr;
        issue     = accept && !t_we;
      end
      ST_DUMP: begin
        rf_we      = 1'b0;
        rf_raddrA  = dump_q;
        issue      = 1'b1;
        issue_addr = dump_q;
        last_beat  = (dump_q == LAST_ADDR);
      end
      default: ;
    endcase
  end

  assign rf_raddrB  = p_raddrB;
  assign issue_data = (issue_addr == ADDR_W'(R0_ADDR)) ? '0 : rf_rdataA;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_NORMAL;
      drain_q <= '0;
      dump_q  <= '0;
      stall_q <= 1'b0;
      grant_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      dump_q  <= dump_d;
      stall_q <= (state_d != ST_NORMAL);
      grant_q <= (state_d == ST_TEST) || (state_d == ST_DUMP);
      ready_q <= (state_d == ST_TEST);
    end
  end

  assign proc_stall = stall_q;
  assign test_grant = grant_q;
  assign t_ready    = ready_q;

  test_port_resp_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_resp (
    .clock   (clock),
    .reset   (reset),
    .issue_i (issue),
    .last_i  (last_beat),
    .addr_i  (issue_addr),
    .data_i  (issue_data),
    .valid_o (r_valid),
    .done_o  (dump_done),
    .addr_o  (r_addr),
    .data_o  (r_data)
  );

endmodule

// File: tb/tb_regfile_test_port.sv
// Scoreboard bench for regfile_test_port with a behavioural regfile and reference model.
module tb_regfile_test_port;

  localparam int NREG  = 32;
  localparam int DRAIN = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        test_req, test_grant;
  logic        t_valid, t_ready, t_we;
  logic [4:0]  t_addr;
  logic [31:0] t_wdata;
  logic        dump_start, dump_done;
  logic        r_valid;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic        p_we;
  logic [4:0]  p_waddr, p_raddrA, p_raddrB;
  logic [31:0] p_wdata;
  logic        proc_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr, rf_raddrA, rf_raddrB;
  logic [31:0] rf_wdata, rf_rdataA;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_rf[NREG];
  logic [31:0] rf_mem[NREG];
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  regfile_test_port dut (
    .clock(clock), .reset(reset), .test_req(test_req), .test_grant(test_grant),
    .t_valid(t_valid), .t_ready(t_ready), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
    .dump_start(dump_start), .dump_done(dump_done),
    .r_valid(r_valid), .r_addr(r_addr), .r_data(r_data),
    .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata), .p_raddrA(p_raddrA), .p_raddrB(p_raddrB),
    .proc_stall(proc_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddrA(rf_raddrA), .rf_raddrB(rf_raddrB), .rf_rdataA(rf_rdataA)
  );

  // Environment regfile: cleared while reset is held, combinational read port A.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_mem[i] <= '0;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdataA = rf_mem[rf_raddrA];

  // Monitor: every response beat pops one expectation.
  always @(negedge clock) begin
    exp_t e;
    if (r_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got addr=%0d data=%h with no expected response", r_addr, r_data);
      end else begin
        e = sb.pop_front();
        if (r_addr !== e.addr || r_data !== e.data || dump_done !== e.done) begin
          fails++;
          $display("FAIL resp: got addr=%0d data=%h done=%b, expected addr=%0d data=%h done=%b",
                   r_addr, r_data, dump_done, e.addr, e.data, e.done);
        end else begin
          $display("[TB] resp addr=%0d data=%h done=%b", r_addr, r_data, dump_done);
        end
      end
    end else if (dump_done) begin
      tests++;
      fails++;
      $display("FAIL dump_done_alone: got dump_done=1 with r_valid=0, expected 0");
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a drive point (just after a rising edge); returns at the next drive point.
  task automatic txn(input logic we, input logic [4:0] a, input logic [31:0] d);
    t_valid = 1'b1; t_we = we; t_addr = a; t_wdata = d;
    if (!we) sb.push_back('{a, ref_rf[a], 1'b0});
    else if (a != 5'd0) ref_rf[a] = d;
    @(negedge clock);
    chk("t_ready_test", t_ready, 1);
    chk("raddrB_pass", rf_raddrB, p_raddrB);
    if (we) begin
      chk("wr_strobe", rf_we, (a != 5'd0));
      if (a != 5'd0) begin
        chk("wr_addr", rf_waddr, a);
        chk("wr_data", rf_wdata, d);
      end
    end
    $display("[TB] txn %s addr=%0d data=%h", we ? "WR" : "RD", a, d);
    @(posedge clock); #1;
    t_valid = 1'b0;
  endtask

  task automatic enter_test();
    int n;
    test_req = 1'b1;
    n = 0;
    while (!test_grant && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    chk("grant_timeout", test_grant, 1);
  endtask

  task automatic run_dump(input int drop_at, input int reset_at);
    dump_start = 1'b1; t_valid = 1'b0;
    for (int i = 0; i < NREG; i++) sb.push_back('{5'(i), ref_rf[i], (i == NREG - 1)});
    @(posedge clock); #1;
    dump_start = 1'b0;
    for (int j = 0; j < NREG; j++) begin
      chk("t_ready_dump", t_ready, 0);
      if (j == drop_at) test_req = 1'b0;
      @(posedge clock); #1;
      if (j == reset_at) begin
        chk("beat_before_reset", {r_valid, 3'b0, r_addr}, {1'b1, 3'b0, 5'(j)});
        reset = 1'b0;
        #1;
        chk("reset_rvalid", r_valid, 0);
        chk("reset_done", dump_done, 0);
        chk("reset_stall", proc_stall, 0);
        chk("reset_grant", test_grant, 0);
        sb.delete();
        $display("[TB] reset asserted at dump beat %0d", j);
        return;
      end
    end
    chk("t_ready_after_dump", t_ready, 1);
    $display("[TB] dump finished");
  endtask

  initial begin
    int k;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;

    for (int i = 0; i < NREG; i++) ref_rf[i] = '0;
    reset = 1'b0; test_req = 1'b1;
    t_valid = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; dump_start = 1'b0;
    p_we = 1'b0; p_waddr = '0; p_wdata = '0; p_raddrA = '0; p_raddrB = '0;

    repeat (3) @(negedge clock);
    chk("rst_grant", test_grant, 0);
    chk("rst_ready", t_ready, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_stall", proc_stall, 0);
    chk("rst_raddr", r_addr, 0);
    chk("rst_rdata", r_data, 0);
    $display("[TB] reset checked");

    // Release; the next edge is where NORMAL sees test_req.
    reset = 1'b1;
    @(posedge clock); #1;
    p_we = 1'b1; p_waddr = 5'd5; p_wdata = 32'd7;
    ref_rf[5] = 32'd7;
    @(negedge clock);
    chk("drain_stall", proc_stall, 1);
    chk("drain_wr_pass", rf_we, 1);
    k = 0;
    while (!test_grant && k < 20) begin
      @(posedge clock); #1;
      p_we = 1'b0;
      k++;
    end
    chk("grant_latency", k, DRAIN + 1);
    $display("[TB] grant after %0d cycles", k);

    txn(1'b1, 5'd1, 32'd65535);
    txn(1'b0, 5'd1, '0);
    txn(1'b1, 5'd0, 32'hDEADBEEF);
    txn(1'b0, 5'd0, '0);
    txn(1'b0, 5'd5, '0);

    // Processor write while the test port owns the regfile must be dropped.
    p_we = 1'b1; p_waddr = 5'd5; p_wdata = 32'd99;
    @(negedge clock);
    chk("proc_wr_blocked", rf_we, 0);
    @(posedge clock); #1;
    p_we = 1'b0;
    txn(1'b0, 5'd5, '0);

    dump_start = 1'b1;
    txn(1'b0, 5'd1, '0);
    dump_start = 1'b0;
    chk("dump_ignored_with_txn", t_ready, 1);

    for (int n = 0; n < 300; n++) begin
      p_we = 1'($urandom); p_waddr = 5'($urandom); p_wdata = $urandom;
      p_raddrA = 5'($urandom); p_raddrB = 5'($urandom);
      if ($urandom_range(0, 4) != 0) begin
        we = 1'($urandom); a = 5'($urandom); d = $urandom;
        txn(we, a, d);
      end else begin
        @(negedge clock);
        chk("idle_no_write", rf_we, 0);
        @(posedge clock); #1;
      end
    end
    p_we = 1'b0;

    run_dump(-1, -1);

    for (int i = 1; i < NREG; i++) txn(1'b1, 5'(i), 32'(i * 3));
    run_dump(-1, -1);

    run_dump(5, -1);
    chk("stall_after_drop_dump", proc_stall, 1);
    @(posedge clock); #1;
    chk("stall_released", proc_stall, 0);
    chk("grant_released", test_grant, 0);

    enter_test();
    run_dump(-1, 10);
    test_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_reset_stall", proc_stall, 0);
    chk("post_reset_grant", test_grant, 0);
    chk("post_reset_rvalid", r_valid, 0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
